// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (imem) and load/store (dmem)
//   clk, rst (async, active low)
//   imem_valid/imem_addr -> imem_ready/imem_rdata  : fetch requester
//   dmem_valid/dmem_addr/dmem_wdata/dmem_wstrb -> dmem_ready/dmem_rdata : load/store requester
//   mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb -> mem_ready/mem_rdata : memory side, registered
//   grant : current owner (00 none, 01 imem, 10 dmem)
//   Define MEM_ARB_ROUND_ROBIN_EN for alternating priority on ties; default is fixed dmem priority.
module mem_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 32,
  parameter int STRB = XLEN / 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_valid,
  input  logic [AW-1:0]   imem_addr,
  output logic            imem_ready,
  output logic [XLEN-1:0] imem_rdata,
  input  logic            dmem_valid,
  input  logic [AW-1:0]   dmem_addr,
  input  logic [XLEN-1:0] dmem_wdata,
  input  logic [STRB-1:0] dmem_wstrb,
  output logic            dmem_ready,
  output logic [XLEN-1:0] dmem_rdata,
  output logic            mem_valid,
  output logic            mem_instr,
  output logic [AW-1:0]   mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [STRB-1:0] mem_wstrb,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [1:0]      grant
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  state_t state;
  logic   pick_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Who wins the next tie: 0 = imem, 1 = dmem; flips to the loser at every grant.
  logic prio_d;
  assign pick_d = dmem_valid && (!imem_valid || prio_d);
`else
  assign pick_d = dmem_valid;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      mem_instr <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      grant     <= 2'b00;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prio_d    <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (imem_valid || dmem_valid) begin
        state     <= pick_d ? BUSY_D : BUSY_I;
        mem_valid <= 1'b1;
        mem_instr <= !pick_d;
        mem_addr  <= pick_d ? dmem_addr : imem_addr;
        mem_wdata <= pick_d ? dmem_wdata : '0;
        mem_wstrb <= pick_d ? dmem_wstrb : '0;
        grant     <= pick_d ? 2'b10 : 2'b01;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        prio_d    <= !pick_d;
`endif
      end
    end else if (mem_ready) begin
      state     <= IDLE;
      mem_valid <= 1'b0;
      grant     <= 2'b00;
    end
  end
  assign imem_ready = (state == BUSY_I) && mem_ready;
  assign dmem_ready = (state == BUSY_D) && mem_ready;
  assign imem_rdata = imem_ready ? mem_rdata : '0;
  assign dmem_rdata = dmem_ready ? mem_rdata : '0;
endmodule
